// File: rtl/serial_frame_pkg.sv
// ---------------------------------------------------------------------------
// serial_frame_pkg
// Shared definitions for the serial frame receiver: FSM state encoding,
// line-level constants for the start/stop bits and a small helper that
// sizes the data-bit counter.
//
// Optional feature macro: PARITY_CHECK_EN (the PARITY state is only
// reachable when the receiver is built with that macro defined).
// ---------------------------------------------------------------------------
package serial_frame_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   // The line idles high, so a frame opens with a low bit and closes with a high one.
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Counter width able to index DATA_W bits (at least one bit wide).
   function automatic int count_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// ---------------------------------------------------------------------------
// serial_frame_rx_if
// Bundles the serial input line, the sample strobe, the valid/ready word
// output and the status pulses of the serial frame receiver.
//
// Signals:
//   serial_in  - serial line, idles high
//   bit_en     - sample strobe
//   out_data   - received word (DATA_W bits)
//   out_valid  - word available
//   out_ready  - consumer accepts the word
//   busy       - receiver is inside a frame
//   frame_err  - stop bit was low (1-cycle pulse)
//   overrun    - good word dropped because the buffer was full (1-cycle pulse)
//   parity_err - parity mismatch (1-cycle pulse, only with PARITY_CHECK_EN)
//
// Modports:
//   master - the side that drives the line and consumes words
//   slave  - the receiver itself
//
// Optional feature macro: PARITY_CHECK_EN adds parity_err.
// ---------------------------------------------------------------------------
interface serial_frame_rx_if #(
   parameter int DATA_W = 4
);

   logic              serial_in;
   logic              bit_en;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              frame_err;
   logic              overrun;
`ifdef PARITY_CHECK_EN
   logic              parity_err;

   modport master (
      output serial_in, bit_en, out_ready,
      input  out_data, out_valid, busy, frame_err, overrun, parity_err
   );

   modport slave (
      input  serial_in, bit_en, out_ready,
      output out_data, out_valid, busy, frame_err, overrun, parity_err
   );
`else
   modport master (
      output serial_in, bit_en, out_ready,
      input  out_data, out_valid, busy, frame_err, overrun
   );

   modport slave (
      input  serial_in, bit_en, out_ready,
      output out_data, out_valid, busy, frame_err, overrun
   );
`endif

endinterface

// File: rtl/serial_frame_rx_out_buffer.sv
// ---------------------------------------------------------------------------
// rx_out_buffer
// One-entry valid/ready holding register for received words.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high
//   load      in   a good word is complete this cycle
//   load_data in   the word to load (DATA_W bits)
//   out_ready in   consumer accepts when out_valid & out_ready
//   out_data  out  held word, stable while out_valid=1
//   out_valid out  word available
//   overrun   out  1-cycle pulse: a load arrived while full and not draining
// ---------------------------------------------------------------------------
module rx_out_buffer #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              overrun
);

   logic              accept;
   logic              full_stalled;

   assign accept       = out_valid & out_ready;
   assign full_stalled = out_valid & ~out_ready;

   // A load into a stalled buffer keeps the older word and flags the drop;
   // a load during an accepting handshake simply replaces the word, so
   // out_valid never drops in that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load) begin
            if (full_stalled) begin
               overrun <= 1'b1;
            end else begin
               out_data  <= load_data;
               out_valid <= 1'b1;
            end
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
// Receives a serial bit stream framed as start(0) + DATA_W data bits
// [+ even parity] + stop(1), one bit per bit_en strobe, and delivers each
// good word through a one-entry valid/ready buffer.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; clears all state
//   bus    slave modport of serial_frame_rx_if (line, strobe, word output,
//          busy, frame_err, overrun, and parity_err when built in)
//
// Parameters:
//   DATA_W     data bits per frame (>= 2)
//   LSB_FIRST  1: first data bit lands in out_data[0]; 0: in out_data[DATA_W-1]
//
// Optional feature macro: PARITY_CHECK_EN adds an even-parity bit after the
// data bits, a PARITY state and the parity_err pulse.
// ---------------------------------------------------------------------------
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input logic             clk,
   input logic             reset,
   serial_frame_rx_if.slave bus
);

   localparam int              CNT_W    = count_width(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   rx_state_t          state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [DATA_W-1:0]  shifter;
   logic               frame_err_q;
   logic               stop_sample;
   logic               stop_good;
   logic               word_good;
`ifdef PARITY_CHECK_EN
   logic               parity_bit;
   logic               parity_ok;
   logic               parity_err_q;
`endif

   // The stop bit is judged in the same cycle it is sampled, so the good
   // word reaches the output buffer on that very edge.
   assign stop_sample = (state == STOP) && bus.bit_en;
   assign stop_good   = (bus.serial_in == STOP_BIT);
`ifdef PARITY_CHECK_EN
   // Even parity: data bits and parity bit together must XOR to zero.
   assign parity_ok   = ((^shifter) == parity_bit);
   assign word_good   = stop_sample && stop_good && parity_ok;
`else
   assign word_good   = stop_sample && stop_good;
`endif

   // Frame FSM with its counter and shifter. Everything advances only on a
   // bit_en strobe; error pulses are registered and cleared every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shifter     <= '0;
         frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_bit   <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err_q <= 1'b0;
`endif
         if (bus.bit_en) begin
            case (state)
               IDLE: begin
                  if (bus.serial_in == START_BIT) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  if (LSB_FIRST) begin
                     shifter <= {bus.serial_in, shifter[DATA_W-1:1]};
                  end else begin
                     shifter <= {shifter[DATA_W-2:0], bus.serial_in};
                  end
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
                     state   <= PARITY;
`else
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               PARITY: begin
`ifdef PARITY_CHECK_EN
                  parity_bit <= bus.serial_in;
                  state      <= STOP;
`else
                  state      <= IDLE;
`endif
               end
               STOP: begin
                  frame_err_q <= ~stop_good;
`ifdef PARITY_CHECK_EN
                  parity_err_q <= ~parity_ok;
`endif
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.frame_err = frame_err_q;
`ifdef PARITY_CHECK_EN
   assign bus.parity_err = parity_err_q;
`endif

   rx_out_buffer #(
      .DATA_W (DATA_W)
   ) u_out_buffer (
      .clk       (clk),
      .reset     (reset),
      .load      (word_good),
      .load_data (shifter),
      .out_ready (bus.out_ready),
      .out_data  (bus.out_data),
      .out_valid (bus.out_valid),
      .overrun   (bus.overrun)
   );

endmodule

// File: tb/tb_serial_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_rx
// Drives an LSB-first and an MSB-first receiver from the same serial line.
// Expected words are queued when frames are sent; monitors pop and compare
// on every handshake. Direct checks cover timing, pulses and reset.
// Optional feature macro: PARITY_CHECK_EN (must match the RTL build).
// ---------------------------------------------------------------------------
module tb_serial_frame_rx;

   localparam int DATA_W = 4;

   logic clk = 1'b0;
   logic reset;
   logic serial_in;
   logic bit_en;
   logic out_ready;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DATA_W-1:0] exp_lsb_q[$];
   logic [DATA_W-1:0] exp_msb_q[$];

   int fe_lsb = 0, fe_msb = 0, ov_lsb = 0, ov_msb = 0;
   int exp_fe = 0, exp_ov = 0;
`ifdef PARITY_CHECK_EN
   int pe_lsb = 0, pe_msb = 0, exp_pe = 0;
`endif

   always #5 clk = ~clk;

   serial_frame_rx_if #(.DATA_W(DATA_W)) bus_lsb ();
   serial_frame_rx_if #(.DATA_W(DATA_W)) bus_msb ();

   assign bus_lsb.serial_in = serial_in;
   assign bus_lsb.bit_en    = bit_en;
   assign bus_lsb.out_ready = out_ready;
   assign bus_msb.serial_in = serial_in;
   assign bus_msb.bit_en    = bit_en;
   assign bus_msb.out_ready = out_ready;

   serial_frame_rx #(.DATA_W(DATA_W), .LSB_FIRST(1'b1)) dut_lsb (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_lsb)
   );

   serial_frame_rx #(.DATA_W(DATA_W), .LSB_FIRST(1'b0)) dut_msb (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_msb)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Scoreboard monitors: a handshake completes on the next rising edge
   // whenever valid and ready are both high at the falling edge.
   always @(negedge clk) begin
      if (bus_lsb.frame_err === 1'b1) fe_lsb++;
      if (bus_lsb.overrun === 1'b1) ov_lsb++;
`ifdef PARITY_CHECK_EN
      if (bus_lsb.parity_err === 1'b1) pe_lsb++;
`endif
      if (!reset && bus_lsb.out_valid === 1'b1 && out_ready) begin
         if (exp_lsb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL lsb_word: got %0h, expected no word", bus_lsb.out_data);
         end else begin
            checkOutput("lsb_word", 32'(bus_lsb.out_data), 32'(exp_lsb_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (bus_msb.frame_err === 1'b1) fe_msb++;
      if (bus_msb.overrun === 1'b1) ov_msb++;
`ifdef PARITY_CHECK_EN
      if (bus_msb.parity_err === 1'b1) pe_msb++;
`endif
      if (!reset && bus_msb.out_valid === 1'b1 && out_ready) begin
         if (exp_msb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL msb_word: got %0h, expected no word", bus_msb.out_data);
         end else begin
            checkOutput("msb_word", 32'(bus_msb.out_data), 32'(exp_msb_q.pop_front()));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One sampled bit, optionally followed by gap cycles of bit_en=0 with
   // the line deliberately flipped to prove it is ignored.
   task automatic drive_bit(input logic b, input int gap);
      serial_in = b;
      bit_en    = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < gap; i++) begin
         bit_en    = 1'b0;
         serial_in = ~b;
         @(posedge clk);
         #1;
      end
      bit_en    = 1'b0;
      serial_in = 1'b1;
   endtask

   // tx[0] is sent first. Returns just after the stop-bit edge.
   task automatic applyStimulus(input logic [DATA_W-1:0] tx, input logic stop_bit,
                                input logic bad_par, input int gap,
                                input logic ready_on_stop);
      drive_bit(1'b0, gap);
      for (int i = 0; i < DATA_W; i++) drive_bit(tx[i], gap);
`ifdef PARITY_CHECK_EN
      drive_bit((^tx) ^ bad_par, gap);
`else
      if (bad_par) $display("[TB] note: frame format carries no parity bit");
`endif
      if (ready_on_stop) out_ready = 1'b1;
      drive_bit(stop_bit, 0);
   endtask

   initial begin
      reset     = 1'b1;
      serial_in = 1'b1;
      bit_en    = 1'b0;
      out_ready = 1'b0;
      idle(3);

      checkOutput("reset_valid", 32'(bus_lsb.out_valid), 32'(0));
      checkOutput("reset_busy", 32'(bus_lsb.busy), 32'(0));
      checkOutput("reset_frame_err", 32'(bus_lsb.frame_err), 32'(0));
      checkOutput("reset_overrun", 32'(bus_lsb.overrun), 32'(0));
      checkOutput("reset_data", 32'(bus_lsb.out_data), 32'(0));
      checkOutput("reset_msb_valid", 32'(bus_msb.out_valid), 32'(0));
      reset = 1'b0;
      idle(2);

      // Line 0,1,0,1,1,1: LSB-first gives 1101, MSB-first gives 1011.
      out_ready = 1'b1;
      exp_lsb_q.push_back(4'b1101);
      exp_msb_q.push_back(4'b1011);
      applyStimulus(4'b1101, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("t1_valid", 32'(bus_lsb.out_valid), 32'(1));
      checkOutput("t2_msb_valid", 32'(bus_msb.out_valid), 32'(1));
      checkOutput("t1_busy", 32'(bus_lsb.busy), 32'(0));
      checkOutput("t1_frame_err", 32'(bus_lsb.frame_err), 32'(0));
      checkOutput("t1_overrun", 32'(bus_lsb.overrun), 32'(0));
      idle(2);
      checkOutput("t1_drained", 32'(bus_lsb.out_valid), 32'(0));

      // Stop bit low: frame error, nothing delivered.
      applyStimulus(4'b0110, 1'b0, 1'b0, 0, 1'b0);
      exp_fe++;
      checkOutput("t3_frame_err", 32'(bus_lsb.frame_err), 32'(1));
      checkOutput("t3_msb_frame_err", 32'(bus_msb.frame_err), 32'(1));
      checkOutput("t3_valid", 32'(bus_lsb.out_valid), 32'(0));
      checkOutput("t3_busy", 32'(bus_lsb.busy), 32'(0));
      idle(1);
      checkOutput("t3_pulse_end", 32'(bus_lsb.frame_err), 32'(0));

      // Two frames with the consumer stalled: the second is dropped.
      out_ready = 1'b0;
      exp_lsb_q.push_back(4'b0011);
      exp_msb_q.push_back(4'b1100);
      applyStimulus(4'b0011, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("t4_first_valid", 32'(bus_lsb.out_valid), 32'(1));
      applyStimulus(4'b0101, 1'b1, 1'b0, 0, 1'b0);
      exp_ov++;
      checkOutput("t4_overrun", 32'(bus_lsb.overrun), 32'(1));
      checkOutput("t4_held_lsb", 32'(bus_lsb.out_data), 32'(4'b0011));
      checkOutput("t4_held_msb", 32'(bus_msb.out_data), 32'(4'b1100));
      checkOutput("t4_still_valid", 32'(bus_lsb.out_valid), 32'(1));
      idle(1);
      checkOutput("t4_overrun_end", 32'(bus_lsb.overrun), 32'(0));
      out_ready = 1'b1;
      idle(2);
      checkOutput("t4_drained", 32'(bus_lsb.out_valid), 32'(0));

      // Stop sample coincides with the handshake of the previous word.
      out_ready = 1'b0;
      exp_lsb_q.push_back(4'b1000);
      exp_msb_q.push_back(4'b0001);
      exp_lsb_q.push_back(4'b0111);
      exp_msb_q.push_back(4'b1110);
      applyStimulus(4'b1000, 1'b1, 1'b0, 0, 1'b0);
      applyStimulus(4'b0111, 1'b1, 1'b0, 0, 1'b1);
      checkOutput("t5_valid", 32'(bus_lsb.out_valid), 32'(1));
      checkOutput("t5_no_overrun", 32'(bus_lsb.overrun), 32'(0));
      checkOutput("t5_new_lsb", 32'(bus_lsb.out_data), 32'(4'b0111));
      checkOutput("t5_new_msb", 32'(bus_msb.out_data), 32'(4'b1110));
      idle(2);
      checkOutput("t5_drained", 32'(bus_lsb.out_valid), 32'(0));

      // Reset with a held word and a frame in progress: both are lost.
      out_ready = 1'b0;
      applyStimulus(4'b1111, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("t6_held", 32'(bus_lsb.out_valid), 32'(1));
      drive_bit(1'b0, 1);
      drive_bit(1'b1, 1);
      drive_bit(1'b0, 0);
      checkOutput("t6_mid_busy", 32'(bus_lsb.busy), 32'(1));
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bit_en    = i[0];
         serial_in = 1'b0;
         @(posedge clk);
         #1;
      end
      checkOutput("t6_reset_busy", 32'(bus_lsb.busy), 32'(0));
      checkOutput("t6_reset_valid", 32'(bus_lsb.out_valid), 32'(0));
      checkOutput("t6_reset_msb_valid", 32'(bus_msb.out_valid), 32'(0));
      reset     = 1'b0;
      bit_en    = 1'b0;
      serial_in = 1'b1;
      idle(1);
      checkOutput("t6_idle_after", 32'(bus_lsb.busy), 32'(0));
      out_ready = 1'b1;
      exp_lsb_q.push_back(4'hA);
      exp_msb_q.push_back(4'h5);
      applyStimulus(4'b1010, 1'b1, 1'b0, 2, 1'b0);
      checkOutput("t6_valid", 32'(bus_lsb.out_valid), 32'(1));
      checkOutput("t6_data", 32'(bus_lsb.out_data), 32'(4'hA));
      checkOutput("t6_frame_err", 32'(bus_lsb.frame_err), 32'(0));
      idle(2);

`ifdef PARITY_CHECK_EN
      // Wrong parity with a good stop bit: word discarded.
      applyStimulus(4'b0110, 1'b1, 1'b1, 0, 1'b0);
      exp_pe++;
      checkOutput("t7_parity_err", 32'(bus_lsb.parity_err), 32'(1));
      checkOutput("t7_frame_err", 32'(bus_lsb.frame_err), 32'(0));
      checkOutput("t7_valid", 32'(bus_lsb.out_valid), 32'(0));
      idle(2);
      checkOutput("pe_count_lsb", 32'(pe_lsb), 32'(exp_pe));
      checkOutput("pe_count_msb", 32'(pe_msb), 32'(exp_pe));
`endif

      checkOutput("fe_count_lsb", 32'(fe_lsb), 32'(exp_fe));
      checkOutput("fe_count_msb", 32'(fe_msb), 32'(exp_fe));
      checkOutput("ov_count_lsb", 32'(ov_lsb), 32'(exp_ov));
      checkOutput("ov_count_msb", 32'(ov_msb), 32'(exp_ov));
      checkOutput("lsb_queue_left", 32'(exp_lsb_q.size()), 32'(0));
      checkOutput("msb_queue_left", 32'(exp_msb_q.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
